dm_store_merge: RTL and testbench
=================================

Name: dm_store_merge

Overview:
- Store-side counterpart of the data-memory load extension path.
- Accepts SB/SH/SW requests from the MEM stage and drives a word-only data memory that has no byte enables.
- Sub-word stores are done as read-modify-write. Full-word stores are written directly.
- Stalls the pipeline through a valid/ready handshake and flags misaligned stores.

Parameters:
- ADDR_W, 10, word-address width of the data memory (1K words = 4 KB).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request from the MEM stage
- st_ready  out  1  block idle; request accepted when st_valid & st_ready
- st_addr  in  32  byte address of the store
- st_data  in  32  store data, right-justified: byte in [7:0], half in [15:0]
- st_ctl  in  2  0=SB, 1=SH, 2=SW, 3=illegal
- st_done  out  1  one-cycle pulse when the store has been written to memory
- st_err  out  1  one-cycle pulse when a store is rejected (misaligned or illegal ctl)
- mem_addr  out  ADDR_W  word address, equal to st_addr[ADDR_W+1:2] latched at accept
- mem_rd  out  1  memory read strobe
- mem_rdata  in  32  memory read data
- mem_rvalid  in  1  mem_rdata valid; arrives at least 1 cycle after mem_rd
- mem_wr  out  1  memory write strobe; memory always accepts in the same cycle
- mem_wdata  out  32  word to write

Behaviour:
- Reset:
  - state=IDLE.
  - st_ready=1; st_done, st_err, mem_rd, mem_wr = 0.
  - mem_addr, mem_wdata = 0.
  - Internal addr/data/ctl/lane registers cleared.
- States: IDLE, READ, WAIT, WRITE, ERR.
- st_ready = (state==IDLE). st_valid is ignored in all other states, so a pending request must be held by the requester.
- IDLE, on accept: latch addr, data, ctl, lane=st_addr[1:0].
  - Misaligned (SH with addr[0]=1; SW with addr[1:0]!=0) or ctl==3 -> ERR.
  - SW aligned -> WRITE, with wbuf=st_data.
  - SB, or SH aligned -> READ.
- READ (exactly 1 cycle): mem_rd=1, then -> WAIT. An mem_rvalid seen during READ is ignored.
- WAIT: hold until mem_rvalid=1, then load wbuf with the merged word and go -> WRITE. There is no timeout.
- Merge rules (little-endian lanes, identical to the load path so a store followed by a load round-trips):
  - SB: wbuf = rdata with byte[lane] replaced by data[7:0]; byte k is bits [8k+7:8k].
  - SH: lane[1]=1 replaces [31:16] with data[15:0]; lane[1]=0 replaces [15:0].
  - Upper bits of st_data beyond the stored width are ignored.
- WRITE (exactly 1 cycle): mem_wr=1, mem_wdata=wbuf, st_done=1, then -> IDLE.
- ERR (exactly 1 cycle): st_err=1, then -> IDLE. No mem_rd or mem_wr is ever issued for a rejected store.
- Latency from accept edge:
  - SW: st_done in the next cycle.
  - SB/SH: mem_rd in cycle +1, st_done 1 cycle after the mem_rvalid cycle.
  - Minimum SB/SH: 4 cycles total.
- mem_addr holds its value from accept until the next accept. mem_rd and mem_wr are never asserted together.
- Back-to-back: a new request can be accepted in the IDLE cycle right after st_done or st_err. There is no bubble beyond IDLE.
- Reset mid-operation (any state):
  - Immediate return to IDLE with all outputs deasserted.
  - A partially merged word is discarded and never written.
  - An mem_rvalid arriving after reset is ignored.
- All outputs are registered or decoded from state only. There are no combinational paths from st_* or mem_* inputs to outputs.

Test Plan:
- SB, addr=0x0000_0006, data=0xFFFF_FFAB, memory word 0x1122_3344 returned 2 cycles after mem_rd -> mem_addr=1, one mem_rd, then mem_wr with mem_wdata=0x11AB_3344 and st_done the same cycle.
- SH, addr=0x0000_000A, data=0x0000_BEEF, memory 0x1122_3344 -> mem_wdata=0xBEEF_3344. Repeat at addr=0x08 -> 0x1122_BEEF.
- SW, addr=0x0000_0010, data=0xDEAD_BEEF -> no mem_rd; mem_wr in the cycle after accept with mem_addr=4, mem_wdata=0xDEAD_BEEF; st_ready low for exactly 1 cycle.
- SH addr=0x1, SW addr=0x2, ctl=3 -> st_err pulse 1 cycle after each accept; mem_rd and mem_wr stay 0 throughout.
- rst_n low during WAIT, then mem_rvalid=1 with 0xAAAA_AAAA -> state IDLE, st_ready=1, mem_wr never asserted, st_done never pulses.
- SB held with st_valid=1 throughout while a prior SB is in WAIT -> st_ready=0 until after st_done; the second store is accepted in the following IDLE cycle and completes with the correct merge.

Source files
------------

// File: rtl/dm_store_merge.sv
// dm_store_merge: SB/SH/SW store path onto a word-only memory, read-modify-write for sub-word stores
module dm_store_merge #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_ctl,
  output logic              st_done,
  output logic              st_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;
  state_t      state_q, state_d;
  logic [15:0] data_q;
  logic [1:0]  ctl_q;
  logic [1:0]  lane_q;
  logic [31:0] merged;
  logic        accept;
  logic        bad;
  logic        unused_addr;
  assign unused_addr = ^st_addr;
  assign accept   = (state_q == IDLE) && st_valid;
  assign bad      = (st_ctl == 2'd3) || (st_ctl == 2'd1 && st_addr[0]) || (st_ctl == 2'd2 && |st_addr[1:0]);
  assign st_ready = (state_q == IDLE);
  assign mem_rd   = (state_q == READ);
  assign mem_wr   = (state_q == WRITE);
  assign st_done  = (state_q == WRITE);
  assign st_err   = (state_q == ERR);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state: classify at accept, single-cycle READ/WRITE/ERR, WAIT holds for read data
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (st_valid) state_d = bad ? ERR : (st_ctl == 2'd2 ? WRITE : READ);
      READ:  state_d = WAIT;
      WAIT:  if (mem_rvalid) state_d = WRITE;
      WRITE: state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // splice the stored byte/half into the returned word on its little-endian lane
  always_comb begin
    merged = mem_rdata;
    if (ctl_q == 2'd1) merged[{lane_q[1], 4'b0000} +: 16] = data_q;
    else merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
  end
  // request latch at accept and write buffer load (direct for SW, merged for SB/SH)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      data_q    <= '0;
      ctl_q     <= '0;
      lane_q    <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      mem_addr <= st_addr[ADDR_W+1:2];
      data_q   <= st_data[15:0];
      ctl_q    <= st_ctl;
      lane_q   <= st_addr[1:0];
      if (st_ctl == 2'd2) mem_wdata <= st_data;
    end else if (state_q == WAIT && mem_rvalid) begin
      mem_wdata <= merged;
    end
  end
endmodule

// File: tb/tb_dm_store_merge.sv
// tb_dm_store_merge: random and directed stores against a shadow memory and expected-event scoreboard
module tb_dm_store_merge;
  logic        clk = 0;
  logic        rst_n;
  logic        st_valid, st_ready, st_done, st_err;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_ctl;
  logic [9:0]  mem_addr;
  logic        mem_rd, mem_wr, mem_rvalid;
  logic [31:0] mem_rdata, mem_wdata;
  logic        rv_a, rv_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] mem [1024];
  int          tests = 0, fails = 0, cyc = 0, rv_cyc = -1, done_cyc = -100, gap = 0;
  int          n_rd = 0, n_wr = 0, n_err = 0, n_done = 0;
  int          fixed_delay = 0;
  bit          resp_en = 1;
  logic [9:0]  last_addr = 0;
  typedef struct {bit err; bit rmw; logic [9:0] addr; logic [31:0] wdata; int acc;} exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [31:0] old_w, mask;
  int          sh;

  assign mem_rvalid = rv_a | rv_b;
  assign mem_rdata  = rv_b ? rdata_b : rdata_a;

  dm_store_merge #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_ctl(st_ctl), .st_done(st_done),
    .st_err(st_err), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_wr(mem_wr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // memory responder: one read-data beat 1..3 cycles after each mem_rd
  initial begin
    int d;
    logic [9:0] ra;
    rv_a = 0;
    rdata_a = 0;
    forever begin
      @(negedge clk);
      if (mem_rd && resp_en && rst_n) begin
        ra = mem_addr;
        d = fixed_delay != 0 ? fixed_delay : int'($urandom_range(1, 3));
        repeat (d) @(posedge clk);
        #1 rv_a = 1;
        rdata_a = mem[ra];
        @(posedge clk);
        #1 rv_a = 0;
        rdata_a = $urandom;
      end
    end
  end

  // compare process: every cycle, DUT outputs against the expected-event queue
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_ready", st_ready, 1);
      chk("rst_strobes", {st_done, st_err, mem_rd, mem_wr}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      q.delete();
      last_addr = 0;
    end else begin
      if (mem_rvalid) rv_cyc = cyc;
      if (mem_rd) n_rd++;
      if (mem_wr) n_wr++;
      if (st_err) n_err++;
      if (st_done) begin n_done++; done_cyc = cyc; end
      chk("ready", st_ready, q.size() == 0);
      chk("rd_wr_excl", mem_rd & mem_wr, 0);
      chk("done_eq_wr", st_done, mem_wr);
      if (q.size() == 0) begin
        chk("idle_strobes", {mem_rd, mem_wr, st_err}, 0);
        chk("idle_addr", mem_addr, last_addr);
      end else begin
        e = q[0];
        chk("mem_addr", mem_addr, e.addr);
        if (e.err) begin
          chk("err_pulse", st_err, 1);
          chk("err_no_mem", {mem_rd, mem_wr}, 0);
          void'(q.pop_front());
        end else if (!e.rmw) begin
          chk("sw_wr", mem_wr, 1);
          chk("sw_rd", {mem_rd, st_err}, 0);
          chk("sw_wdata", mem_wdata, e.wdata);
          mem[mem_addr] = mem_wdata;
          void'(q.pop_front());
        end else begin
          chk("rmw_err", st_err, 0);
          chk("rmw_rd", mem_rd, cyc == e.acc + 1);
          chk("rmw_wr", mem_wr, rv_cyc > e.acc + 1 && cyc == rv_cyc + 1);
          if (mem_wr) begin
            chk("rmw_wdata", mem_wdata, e.wdata);
            mem[mem_addr] = mem_wdata;
            void'(q.pop_front());
          end else if (cyc > e.acc + 20) begin
            chk("rmw_stall", 1, 0);
            void'(q.pop_front());
          end
        end
      end
      if (st_valid && st_ready) begin
        e.addr = st_addr[11:2];
        e.err = st_ctl == 3 || (st_ctl == 1 && st_addr[0]) || (st_ctl == 2 && st_addr[1:0] != 0);
        e.rmw = st_ctl != 2;
        e.acc = cyc;
        sh = 8 * int'(st_addr[1:0]);
        mask = (st_ctl == 0 ? 32'hFF : 32'hFFFF) << sh;
        old_w = mem[e.addr];
        e.wdata = st_ctl == 2 ? st_data : (old_w & ~mask) | ((st_data << sh) & mask);
        gap = cyc - done_cyc;
        last_addr = e.addr;
        q.push_back(e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_store(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d, input bit hold);
    int n = 0;
    st_valid = 1;
    st_ctl = c;
    st_addr = a;
    st_data = d;
    @(negedge clk);
    while (!st_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) begin
      st_valid = 0;
      st_ctl = 2'($urandom);
      st_addr = $urandom;
      st_data = $urandom;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(q.size() == 0 && st_ready) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b_rd, b_wr, b_err, b_done, n;
    rst_n = 0;
    st_valid = 0;
    st_addr = 0;
    st_data = 0;
    st_ctl = 0;
    rv_b = 0;
    rdata_b = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'h1122_3344;
    step(3);
    rst_n = 1;
    step(1);
    fixed_delay = 2;
    b_rd = n_rd;
    do_store(2'd0, 32'h0000_0006, 32'hFFFF_FFAB, 0);
    wait_idle();
    chk("sb_word", mem[1], 32'h11AB_3344);
    chk("sb_rd_count", n_rd - b_rd, 1);
    chk("sb_addr", mem_addr, 1);
    do_store(2'd1, 32'h0000_000A, 32'h0000_BEEF, 0);
    wait_idle();
    chk("sh_hi_word", mem[2], 32'hBEEF_3344);
    mem[2] = 32'h1122_3344;
    do_store(2'd1, 32'h0000_0008, 32'h0000_BEEF, 0);
    wait_idle();
    chk("sh_lo_word", mem[2], 32'h1122_BEEF);
    b_rd = n_rd;
    do_store(2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    wait_idle();
    chk("sw_word", mem[4], 32'hDEAD_BEEF);
    chk("sw_rd_count", n_rd - b_rd, 0);
    chk("sw_addr", mem_addr, 4);
    b_rd = n_rd;
    b_wr = n_wr;
    b_err = n_err;
    do_store(2'd1, 32'h0000_0001, $urandom, 0);
    wait_idle();
    do_store(2'd2, 32'h0000_0002, $urandom, 0);
    wait_idle();
    do_store(2'd3, 32'h0000_0020, $urandom, 0);
    wait_idle();
    chk("err_count", n_err - b_err, 3);
    chk("err_mem_count", (n_rd - b_rd) + (n_wr - b_wr), 0);
    fixed_delay = 3;
    mem[5] = 32'h1122_3344;
    do_store(2'd0, 32'h0000_0014, 32'h0000_005A, 1);
    do_store(2'd0, 32'h0000_0017, 32'hFFFF_FFC3, 0);
    wait_idle();
    chk("held_word", mem[5], 32'hC322_335A);
    chk("held_gap", gap, 1);
    fixed_delay = 0;
    resp_en = 0;
    mem[6] = 32'h1122_3344;
    b_wr = n_wr;
    b_done = n_done;
    do_store(2'd0, 32'h0000_0018, 32'h0000_0077, 0);
    n = 0;
    @(negedge clk);
    while (!mem_rd && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("rd_timeout", 0, 1);
    @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    rv_b = 1;
    rdata_b = 32'hAAAA_AAAA;
    step(1);
    rv_b = 0;
    step(3);
    chk("rst_ready_after", st_ready, 1);
    chk("rst_word_kept", mem[6], 32'h1122_3344);
    chk("rst_no_wr", n_wr - b_wr, 0);
    chk("rst_no_done", n_done - b_done, 0);
    resp_en = 1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [1:0]  c;
      c = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[31:5] = '0;
      do_store(c, a, $urandom, 0);
      step(int'($urandom_range(0, 2)));
    end
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
